// File: rtl/cordic_cfg_ctrl.sv
// Configuration/sequencing controller for the pipelined CORDIC DDS core:
// streams the coefficient table in, flushes the pipeline, then runs with an optional fcw sweep.
module cordic_cfg_ctrl #(
  parameter int ENTRIES   = 64,
  parameter int FLUSH_CYC = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       run_start,
  input  logic                       stop,
  input  logic [15:0]                hw_data,
  input  logic                       hw_valid,
  output logic                       hw_ready,
  input  logic                       sweep_en,
  input  logic [15:0]                fcw_start,
  input  logic [15:0]                fcw_step,
  input  logic [15:0]                fcw_stop,
  input  logic [15:0]                dwell,
  input  logic [15:0]                offset_in,
  output logic                       cen,
  output logic                       wen,
  output logic [$clog2(ENTRIES)-1:0] index_wri,
  output logic [47:0]                D,
  output logic [15:0]                fcw,
  output logic [15:0]                offset,
  output logic                       busy,
  output logic                       loaded,
  output logic                       sweep_done
);

  localparam int IW = $clog2(ENTRIES);
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [1:0]      r_word_cnt;
  logic [IW-1:0]   r_entry_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic [15:0]     r_dwell_cnt;
  logic [31:0]     r_asm;
  logic            r_hw_ready, r_cen, r_wen, r_busy, r_loaded, r_sweep_done;
  logic [IW-1:0]   r_index;
  logic [47:0]     r_d;
  logic [15:0]     r_fcw, r_offset;

  logic            w_xfer, w_last_word, w_dwell_hit, w_wrap;
  logic [15:0]     w_dwell_inc, w_dwell_max;
  logic [16:0]     w_sum;

  // hw_ready is only ever high while in LOAD, so it alone qualifies a transfer
  assign w_xfer      = hw_valid & r_hw_ready;
  assign w_last_word = w_xfer && (r_word_cnt == 2'd2);
  assign w_dwell_inc = r_dwell_cnt + 16'd1;
  assign w_dwell_max = (dwell == 16'd0) ? 16'd1 : dwell;
  assign w_dwell_hit = (w_dwell_inc >= w_dwell_max);
  assign w_sum       = {1'b0, r_fcw} + {1'b0, fcw_step};
  assign w_wrap      = w_sum[16] || (w_sum[15:0] > fcw_stop);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_start)                w_state_next = S_LOAD;
        else if (run_start && r_loaded) w_state_next = S_RUN;
      end
      S_LOAD: begin
        if (stop) w_state_next = S_IDLE;
        else if (w_last_word && (r_entry_cnt == IW'(ENTRIES - 1))) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (stop) w_state_next = S_IDLE;
        else if (r_flush_cnt == FW'(FLUSH_CYC)) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (stop)            w_state_next = S_IDLE;
        else if (load_start) w_state_next = S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt   <= '0;
      r_entry_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_dwell_cnt  <= '0;
      r_asm        <= '0;
      r_hw_ready   <= 1'b0;
      r_cen        <= 1'b0;
      r_wen        <= 1'b0;
      r_busy       <= 1'b0;
      r_loaded     <= 1'b0;
      r_sweep_done <= 1'b0;
      r_index      <= '0;
      r_d          <= '0;
      r_fcw        <= '0;
      r_offset     <= '0;
    end else begin
      r_wen        <= 1'b0;
      r_sweep_done <= 1'b0;
      r_busy       <= (w_state_next != S_IDLE);
      r_hw_ready   <= (w_state_next == S_LOAD);
      r_cen        <= (w_state_next == S_RUN);

      if (r_state != S_LOAD && w_state_next == S_LOAD) begin
        r_loaded    <= 1'b0;
        r_word_cnt  <= '0;
        r_entry_cnt <= '0;
      end

      if (r_state != S_RUN && w_state_next == S_RUN) begin
        r_fcw       <= fcw_start;
        r_offset    <= offset_in;
        r_dwell_cnt <= '0;
      end

      case (r_state)
        S_LOAD: begin
          if (!stop && w_xfer) begin
            case (r_word_cnt)
              2'd0:    begin r_asm[31:16] <= hw_data; r_word_cnt <= 2'd1; end
              2'd1:    begin r_asm[15:0]  <= hw_data; r_word_cnt <= 2'd2; end
              default: begin
                r_d         <= {r_asm, hw_data};
                r_index     <= r_entry_cnt;
                r_wen       <= 1'b1;
                r_entry_cnt <= r_entry_cnt + 1'b1;
                r_word_cnt  <= 2'd0;
              end
            endcase
          end
          if (w_state_next == S_FLUSH) r_flush_cnt <= '0;
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
          if (w_state_next == S_RUN) r_loaded <= 1'b1;
        end
        S_RUN: begin
          // step only while staying in RUN so fcw holds its last value on exit
          if (w_state_next == S_RUN) begin
            if (w_dwell_hit) begin
              r_dwell_cnt <= '0;
              if (sweep_en) begin
                if (w_wrap) begin
                  r_fcw        <= fcw_start;
                  r_sweep_done <= 1'b1;
                end else begin
                  r_fcw <= w_sum[15:0];
                end
              end
            end else begin
              r_dwell_cnt <= w_dwell_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hw_ready   = r_hw_ready;
  assign cen        = r_cen;
  assign wen        = r_wen;
  assign index_wri  = r_index;
  assign D          = r_d;
  assign fcw        = r_fcw;
  assign offset     = r_offset;
  assign busy       = r_busy;
  assign loaded     = r_loaded;
  assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_cordic_cfg_ctrl.sv
// Directed testbench for cordic_cfg_ctrl: table loads, sweep, carry wrap, aborts and reset.
module tb_cordic_cfg_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, run_start, stop, hw_valid, sweep_en;
  logic [15:0] hw_data, fcw_start, fcw_step, fcw_stop, dwell, offset_in;
  logic        hw_ready, cen, wen, busy, loaded, sweep_done;
  logic [5:0]  index_wri;
  logic [47:0] D;
  logic [15:0] fcw, offset;

  int n_cmp = 0;
  int n_err = 0;

  cordic_cfg_ctrl #(.ENTRIES(64), .FLUSH_CYC(7)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .run_start(run_start), .stop(stop),
    .hw_data(hw_data), .hw_valid(hw_valid), .hw_ready(hw_ready), .sweep_en(sweep_en),
    .fcw_start(fcw_start), .fcw_step(fcw_step), .fcw_stop(fcw_stop), .dwell(dwell),
    .offset_in(offset_in), .cen(cen), .wen(wen), .index_wri(index_wri), .D(D), .fcw(fcw),
    .offset(offset), .busy(busy), .loaded(loaded), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; run_start = 1'b0; stop = 1'b0; hw_valid = 1'b0;
    hw_data = 16'h0; sweep_en = 1'b0; fcw_start = 16'h0; fcw_step = 16'h0;
    fcw_stop = 16'h0; dwell = 16'h0; offset_in = 16'h0;
    tick(); tick(); tick();
    reset = 1'b0;
    n_cmp++; if ({cen, wen, busy, loaded, sweep_done, hw_ready} !== 6'b0)
      begin n_err++; $display("FAIL reset_flags got %b want 000000", {cen, wen, busy, loaded, sweep_done, hw_ready}); end
    n_cmp++; if ({index_wri, D} !== 54'h0)
      begin n_err++; $display("FAIL reset_wrport got idx %h D %h want 0", index_wri, D); end
    n_cmp++; if ({fcw, offset} !== 32'h0)
      begin n_err++; $display("FAIL reset_fcw_offset got %h %h want 0", fcw, offset); end
    $display("test_reset done");
  endtask

  // Issues load_start, streams words 0..191 and checks every write plus the flush delay.
  task automatic test_load(input bit toggle);
    int n, e, cyc, last_wen, extra;
    bit acc;
    logic [15:0] w0, w1, w2;
    n = 0; e = 0; cyc = 0; last_wen = 0; extra = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++; if ({busy, hw_ready, cen, loaded} !== 4'b1100)
      begin n_err++; $display("FAIL load_entry got busy/rdy/cen/ld %b want 1100", {busy, hw_ready, cen, loaded}); end
    while (n < 192 && cyc < 1000) begin
      hw_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      hw_data  = 16'(n);
      acc      = hw_valid && hw_ready;
      tick(); cyc++;
      if (acc) n++;
      if (wen === 1'b1) begin
        w0 = 16'(3 * e); w1 = 16'(3 * e + 1); w2 = 16'(3 * e + 2);
        n_cmp++; if (index_wri !== 6'(e) || D !== {w0, w1, w2})
          begin n_err++; $display("FAIL load_write got idx %0d D %h want idx %0d D %h", index_wri, D, e, {w0, w1, w2}); end
        e++; last_wen = cyc;
      end
    end
    hw_valid = 1'b0;
    for (int i = 0; i < 20 && cen !== 1'b1; i++) begin
      tick(); cyc++;
      if (wen === 1'b1) extra++;
    end
    n_cmp++; if (e !== 64 || extra !== 0)
      begin n_err++; $display("FAIL load_count got %0d writes (+%0d extra) want 64", e, extra); end
    n_cmp++; if (cen !== 1'b1 || (cyc - last_wen) !== 8)
      begin n_err++; $display("FAIL flush_delay got cen %b after %0d cycles want 1 after 8", cen, cyc - last_wen); end
    n_cmp++; if (loaded !== 1'b1 || fcw !== fcw_start || offset !== offset_in)
      begin n_err++; $display("FAIL run_entry got ld %b fcw %h off %h want 1 %h %h", loaded, fcw, offset, fcw_start, offset_in); end
    $display("test_load toggle=%0d done, %0d writes", toggle, e);
  endtask

  task automatic test_sweep();
    logic [15:0] exp_f;
    bit exp_d;
    for (int k = 0; k < 40; k++) begin
      exp_f = 16'h1000 + 16'(((k / 4) % 4) * 256);
      exp_d = (k >= 16) && ((k % 16) == 0);
      n_cmp++; if (fcw !== exp_f || sweep_done !== exp_d || cen !== 1'b1)
        begin n_err++; $display("FAIL sweep k=%0d got fcw %h done %b cen %b want %h %b 1", k, fcw, sweep_done, cen, exp_f, exp_d); end
      tick();
    end
    $display("test_sweep done");
  endtask

  task automatic test_carry();
    logic [15:0] exp_f;
    bit exp_d;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if ({cen, busy, loaded} !== 3'b001 || fcw !== 16'h1200 || offset !== 16'h1234)
      begin n_err++; $display("FAIL run_stop got cen/busy/ld %b fcw %h off %h want 001 1200 1234", {cen, busy, loaded}, fcw, offset); end
    fcw_start = 16'hFF00; fcw_step = 16'h0080; fcw_stop = 16'hFFFF; dwell = 16'h0; offset_in = 16'hABCD;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    n_cmp++; if (cen !== 1'b1 || offset !== 16'hABCD)
      begin n_err++; $display("FAIL run_start got cen %b off %h want 1 abcd", cen, offset); end
    for (int k = 0; k < 10; k++) begin
      exp_f = ((k % 2) == 1) ? 16'hFF80 : 16'hFF00;
      exp_d = (k > 0) && ((k % 2) == 0);
      n_cmp++; if (fcw !== exp_f || sweep_done !== exp_d)
        begin n_err++; $display("FAIL carry k=%0d got fcw %h done %b want %h %b", k, fcw, sweep_done, exp_f, exp_d); end
      tick();
    end
    $display("test_carry done");
  endtask

  task automatic test_stop_load();
    int n, writes;
    n = 0; writes = 0;
    stop = 1'b1; tick(); stop = 1'b0;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int c = 0; c < 300 && n < 100; c++) begin
      hw_valid = 1'b1;
      hw_data  = 16'(n);
      if (hw_ready === 1'b1) n++;
      tick();
      if (wen === 1'b1) writes++;
    end
    hw_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (writes !== 33)
      begin n_err++; $display("FAIL partial_writes got %0d want 33", writes); end
    n_cmp++; if ({busy, loaded, hw_ready, cen} !== 4'b0000)
      begin n_err++; $display("FAIL load_abort got busy/ld/rdy/cen %b want 0000", {busy, loaded, hw_ready, cen}); end
    run_start = 1'b1; tick(); run_start = 1'b0;
    n_cmp++; if ({cen, busy} !== 2'b00)
      begin n_err++; $display("FAIL run_ignored got cen/busy %b want 00", {cen, busy}); end
    $display("test_stop_load done");
  endtask

  task automatic test_reset_mid_run();
    test_load(1'b0);
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if ({cen, wen, busy, loaded, sweep_done, hw_ready} !== 6'b0)
      begin n_err++; $display("FAIL midrun_reset_flags got %b want 000000", {cen, wen, busy, loaded, sweep_done, hw_ready}); end
    n_cmp++; if ({index_wri, D, fcw, offset} !== 86'h0)
      begin n_err++; $display("FAIL midrun_reset_data got idx %h D %h fcw %h off %h want 0", index_wri, D, fcw, offset); end
    run_start = 1'b1; tick(); run_start = 1'b0;
    n_cmp++; if ({cen, busy} !== 2'b00)
      begin n_err++; $display("FAIL post_reset_run got cen/busy %b want 00", {cen, busy}); end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    test_reset();
    sweep_en = 1'b1; fcw_start = 16'h1000; fcw_step = 16'h0100; fcw_stop = 16'h1300;
    dwell = 16'd4; offset_in = 16'h1234;
    test_load(1'b0);
    test_sweep();
    test_carry();
    test_load(1'b1);
    test_stop_load();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
